// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide memory sequencer shared between instruction
// fetch and the load/store buffer. Requests are split into one byte access per
// cycle, read data is assembled little-endian, and completion is a done pulse.
module mem_ctrl #(
  parameter int IF_BYTES = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [8*IF_BYTES-1:0] if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_size,
  input  logic [31:0]           lsb_addr,
  input  logic [31:0]           lsb_wdata,
  output logic                  lsb_done,
  output logic [31:0]           lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr
);

  typedef enum logic [2:0] {S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR, S_DONE} state_t;

  localparam logic G_IF  = 1'b0;
  localparam logic G_LSB = 1'b1;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;      // bytes handled so far in this transaction
  logic [2:0]            n_q, n_d;          // byte count of this transaction
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [55:0]           buf_q, buf_d;      // read assembly buffer, widest fetch is 7 bytes
  logic                  last_q, last_d;    // owner of the most recent grant
  logic [31:0]           mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic [8*IF_BYTES-1:0] if_data_q, if_data_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;

  logic [3:0]            nxt_s;             // index of the next byte to issue
  logic [2:0]            lsb_n_s;           // byte count implied by lsb_size

  // Decode the load/store size; the reserved encoding behaves as a word.
  always_comb begin
    lsb_n_s = 3'd4;
    case (lsb_size)
      2'b00:   lsb_n_s = 3'd1;
      2'b01:   lsb_n_s = 3'd2;
      default: lsb_n_s = 3'd4;
    endcase
  end

  // Next-state, arbitration and byte sequencing; everything holds while rdy_in is low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    last_d      = last_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = if_done_q;
    if_data_d   = if_data_q;
    lsb_done_d  = lsb_done_q;
    lsb_rdata_d = lsb_rdata_q;
    nxt_s       = {1'b0, cnt_q} + 4'd1;

    if (rdy_in) begin
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          mem_wr_d = 1'b0;
          if (clear) begin
            state_d = S_IDLE;
          end else if (if_req && (!lsb_req || (last_q == G_LSB))) begin
            state_d = S_IF_RD;
            last_d  = G_IF;
            addr_d  = if_addr;
            n_d     = 3'(IF_BYTES);
            cnt_d   = 3'd0;
            buf_d   = 56'd0;
            mem_a_d = if_addr;
          end else if (lsb_req) begin
            last_d  = G_LSB;
            addr_d  = lsb_addr;
            wdata_d = lsb_wdata;
            n_d     = lsb_n_s;
            cnt_d   = 3'd0;
            buf_d   = 56'd0;
            mem_a_d = lsb_addr;
            if (lsb_wr) begin
              state_d    = S_LS_WR;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d = S_LS_RD;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_IF_RD, S_LS_RD: begin
          mem_wr_d = 1'b0;
          if (clear) begin
            // a flushed read has no side effects, so drop it on the spot
            state_d = S_IDLE;
          end else begin
            // mem_din lags the address by one cycle, so it belongs to byte cnt-1
            if (cnt_q != 3'd0) begin
              buf_d[{cnt_q - 3'd1, 3'b000} +: 8] = mem_din;
            end else begin
              buf_d = buf_q;
            end
            if (nxt_s < {1'b0, n_q}) begin
              mem_a_d = addr_q + {28'd0, nxt_s};
            end else begin
              mem_a_d = mem_a_q;
            end
            if (cnt_q == n_q) begin
              state_d = S_DONE;
              if (state_q == S_IF_RD) begin
                if_done_d = 1'b1;
                if_data_d = buf_d[8*IF_BYTES-1:0];
              end else begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = buf_d[31:0];
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_LS_WR: begin
          // stores are committed once started, so clear is ignored here
          if (nxt_s < {1'b0, n_q}) begin
            mem_a_d    = addr_q + {28'd0, nxt_s};
            mem_dout_d = wdata_q[{nxt_s[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end else begin
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
            state_d    = S_DONE;
          end
        end
        S_DONE: begin
          mem_wr_d = 1'b0;
          state_d  = S_IDLE;
        end
        default: begin
          mem_wr_d = 1'b0;
          state_d  = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 56'd0;
      last_q      <= G_LSB;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      last_q      <= last_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors for mem_ctrl with a small byte RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [512];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] wd;

  mem_ctrl #(.IF_BYTES(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM indexed by the low 9 address bits; it shares the global enable.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) ram[mem_a[8:0]] <= mem_dout;
      mem_din <= ram[mem_a[8:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[9'h100] = 8'h13; ram[9'h101] = 8'h05; ram[9'h102] = 8'h00; ram[9'h103] = 8'h00;
    ram[9'h1FF] = 8'h34; ram[9'h000] = 8'h12;
    mem_din = 8'h00;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h0; lsb_wdata = 32'h0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // reset values
    chk("rst_mem_a", mem_a, 64'h0);
    chk("rst_mem_wr", mem_wr, 64'h0);
    chk("rst_mem_dout", mem_dout, 64'h0);
    chk("rst_if_done", if_done, 64'h0);
    chk("rst_if_data", if_data, 64'h0);
    chk("rst_lsb_done", lsb_done, 64'h0);
    chk("rst_lsb_rdata", lsb_rdata, 64'h0);

    // 4-byte fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c <= 4) chk("if_mem_a", mem_a, 64'(32'h100 + c - 1));
      chk("if_mem_wr", mem_wr, 64'h0);
      chk("if_done", if_done, 64'(c == 6));
      if (c == 6) begin
        chk("if_data", if_data, 64'h0000_0513);
        if_req = 1'b0;
      end
    end

    // store word at 0x20
    wd = 32'hDEADBEEF;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h20; lsb_wdata = wd;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        chk("sw_mem_a", mem_a, 64'(32'h20 + c - 1));
        chk("sw_mem_dout", mem_dout, 64'(wd[8*(c-1) +: 8]));
        chk("sw_mem_wr", mem_wr, 64'h1);
      end
      chk("sw_lsb_done", lsb_done, 64'(c == 5));
      if (c == 5) begin
        chk("sw_mem_wr_end", mem_wr, 64'h0);
        lsb_req = 1'b0;
      end
    end
    chk("sw_ram", {ram[9'h023], ram[9'h022], ram[9'h021], ram[9'h020]}, 64'hDEADBEEF);

    // both requesting right after reset: IF, then LSB, then IF
    pulse_reset();
    if_req = 1'b1; if_addr = 32'h100;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h20;
    for (int c = 1; c <= 21; c++) begin
      step();
      chk("rr_if_done", if_done, 64'((c == 6) || (c == 20)));
      chk("rr_lsb_done", lsb_done, 64'(c == 13));
      if (c == 1)  chk("rr_mem_a_if", mem_a, 64'h100);
      if (c == 8)  chk("rr_mem_a_lsb", mem_a, 64'h20);
      if (c == 15) chk("rr_mem_a_if2", mem_a, 64'h100);
      if (c == 13) begin
        chk("rr_lsb_rdata", lsb_rdata, 64'hDEADBEEF);
        lsb_req = 1'b0;
      end
      if (c == 20) begin
        chk("rr_if_data", if_data, 64'h0000_0513);
        if_req = 1'b0;
      end
    end

    // halfword load across the address wrap
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b01; lsb_addr = 32'hFFFF_FFFF;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) chk("lh_mem_a0", mem_a, 64'hFFFF_FFFF);
      if (c == 2) chk("lh_mem_a1", mem_a, 64'h0);
      chk("lh_lsb_done", lsb_done, 64'(c == 4));
      if (c == 4) begin
        chk("lh_rdata", lsb_rdata, 64'h0000_1234);
        lsb_req = 1'b0;
      end
    end

    // clear during a fetch aborts it
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("clr_if_done", if_done, 64'h0);
      chk("clr_if_mem_wr", mem_wr, 64'h0);
      if (c == 2) begin
        chk("clr_if_mem_a2", mem_a, 64'h101);
        clear = 1'b1; if_req = 1'b0;
      end
      if (c == 3) begin
        chk("clr_if_mem_a3", mem_a, 64'h101);
        clear = 1'b0;
      end
    end

    // clear during a store does not stop it
    wd = 32'h11223344;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h40; lsb_wdata = wd;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        chk("clr_sw_mem_a", mem_a, 64'(32'h40 + c - 1));
        chk("clr_sw_mem_dout", mem_dout, 64'(wd[8*(c-1) +: 8]));
        chk("clr_sw_mem_wr", mem_wr, 64'h1);
      end
      if (c == 2) clear = 1'b1;
      if (c == 3) clear = 1'b0;
      chk("clr_sw_lsb_done", lsb_done, 64'(c == 5));
      if (c == 5) begin
        chk("clr_sw_mem_wr_end", mem_wr, 64'h0);
        lsb_req = 1'b0;
      end
    end
    chk("clr_sw_ram", {ram[9'h043], ram[9'h042], ram[9'h041], ram[9'h040]}, 64'h11223344);

    // three-cycle stall during a word load
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) chk("stl_mem_a0", mem_a, 64'h40);
      if (c >= 2 && c <= 5) chk("stl_mem_a_frozen", mem_a, 64'h41);
      if (c == 6) chk("stl_mem_a2", mem_a, 64'h42);
      if (c == 7) chk("stl_mem_a3", mem_a, 64'h43);
      chk("stl_lsb_done", lsb_done, 64'(c == 9));
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c == 9) begin
        chk("stl_rdata", lsb_rdata, 64'h11223344);
        lsb_req = 1'b0;
      end
    end

    // reset in the middle of a word load
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h20;
    repeat (3) step();
    #2 rst_in = 1'b1;
    #1;
    chk("rlw_mem_a", mem_a, 64'h0);
    chk("rlw_lsb_done", lsb_done, 64'h0);
    chk("rlw_lsb_rdata", lsb_rdata, 64'h0);
    chk("rlw_if_data", if_data, 64'h0);
    lsb_req = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("rlw_no_done", lsb_done, 64'h0);
    end

    // reset in the middle of a store drops mem_wr at once
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h60; lsb_wdata = 32'hCAFEF00D;
    repeat (2) step();
    chk("rsw_mem_wr_before", mem_wr, 64'h1);
    #2 rst_in = 1'b1;
    #1;
    chk("rsw_mem_wr_after", mem_wr, 64'h0);
    lsb_req = 1'b0;
    @(posedge clk_in);
    #1 rst_in = 1'b0;

    // clear in IDLE suppresses the grant for that cycle
    clear = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h100;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) clear = 1'b0;
      chk("idle_clr_done", lsb_done, 64'(c == 4));
      if (c == 4) begin
        chk("idle_clr_rdata", lsb_rdata, 64'h13);
        lsb_req = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
